// File: rtl/mem_arbiter.sv
// mem_arbiter: sequences one CPU step into fetch, data-access and commit
// phases over a single-port synchronous RAM shared by the instruction and
// data ports. The datapath is held with stall until the step's accesses
// complete, then released for exactly one commit cycle (DONE).
module mem_arbiter #(
   parameter int unsigned RD_LATENCY = 1
) (
   input  logic        clk,
   input  logic        cpu_rst,
   input  logic        cpu_en,
   input  logic        inst_ren,
   input  logic [31:0] inst_addr,
   output logic [31:0] inst_data,
   input  logic        mem_ren,
   input  logic        mem_wen,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_dout,
   output logic [31:0] mem_din,
   output logic        stall,
   output logic        ram_en,
   output logic        ram_we,
   output logic [31:0] ram_addr,
   output logic [31:0] ram_wdata,
   input  logic [31:0] ram_rdata
);

   typedef enum logic [2:0] {
      IDLE,
      I_REQ,
      I_WAIT,
      D_SEL,
      D_REQ,
      D_WAIT,
      D_WR,
      DONE
   } state_t;

   // Wait cycles remaining after the request cycle's follow-on cycle.
   localparam logic [2:0] CNT_INIT = 3'(RD_LATENCY - 1);

   state_t     state;
   logic [2:0] cnt;

   // Step sequencer with registered RAM strobes, address/data and captures.
   always_ff @(posedge clk) begin
      if (cpu_rst) begin
         state     <= IDLE;
         cnt       <= '0;
         ram_en    <= 1'b0;
         ram_we    <= 1'b0;
         ram_addr  <= '0;
         ram_wdata <= '0;
         inst_data <= '0;
         mem_din   <= '0;
      end else begin
         // Strobes are single-cycle: only set on entry to a request state.
         ram_en <= 1'b0;
         ram_we <= 1'b0;
         case (state)
            IDLE: begin
               if (cpu_en) begin
                  if (inst_ren) begin
                     state    <= I_REQ;
                     ram_en   <= 1'b1;
                     ram_addr <= inst_addr;
                  end else begin
                     state <= D_SEL;
                  end
               end
            end
            I_REQ: begin
               state <= I_WAIT;
               cnt   <= CNT_INIT;
            end
            I_WAIT: begin
               if (cnt != 3'd0) begin
                  cnt <= cnt - 3'd1;
               end else begin
                  inst_data <= ram_rdata;
                  state     <= D_SEL;
               end
            end
            D_SEL: begin
               if (mem_wen) begin
                  state     <= D_WR;
                  ram_en    <= 1'b1;
                  ram_we    <= 1'b1;
                  ram_addr  <= mem_addr;
                  ram_wdata <= mem_dout;
               end else if (mem_ren) begin
                  state    <= D_REQ;
                  ram_en   <= 1'b1;
                  ram_addr <= mem_addr;
               end else begin
                  state <= DONE;
               end
            end
            D_REQ: begin
               state <= D_WAIT;
               cnt   <= CNT_INIT;
            end
            D_WAIT: begin
               if (cnt != 3'd0) begin
                  cnt <= cnt - 3'd1;
               end else begin
                  mem_din <= ram_rdata;
                  state   <= DONE;
               end
            end
            D_WR: begin
               state <= DONE;
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Commit is permitted only in DONE; decoded from the state register alone.
   always_comb begin
      stall = (state != DONE);
   end

endmodule
